// File: rtl/fifo_tx_pkg.sv
// Shared types and line levels for the FIFO-draining serial transmitter.
package fifo_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam logic TX_IDLE_LEVEL = 1'b1;
   localparam logic START_LEVEL   = 1'b0;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps,
// held at zero while clear is high. Shared with the future receiver.
module bit_timer #(
   parameter int  CLKS_PER_BIT = 16,
   localparam int CW           = $clog2(CLKS_PER_BIT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   output logic [CW-1:0] count,
   output logic          last_tick
);

   localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

   assign last_tick = (count == LAST_COUNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || last_tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_serial_tx.sv
// Serial transmitter that pulls one word per frame from a FIFO read port and
// sends it as start bit, data LSB first, then stop bit(s).
module fifo_serial_tx
   import fifo_tx_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_val,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic [CW-1:0] NEAR_END  = CW'(CLKS_PER_BIT - 2);

   tx_state_t             state;
   tx_state_t             next_state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shift_d;
   logic [BW-1:0]         bit_cnt;
   logic [BW-1:0]         bit_cnt_d;
   logic [CW-1:0]         tick_count;
   logic                  last_tick;
   logic                  timer_clear;
   logic                  tx_d;
   logic                  rd_en_d;
   logic                  busy_d;
   logic                  done_d;

   assign timer_clear = !(state inside {START, DATA, STOP});

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (timer_clear),
      .count    (tick_count),
      .last_tick(last_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (enable) next_state = REQ;
         REQ:     next_state = WAIT;
         WAIT:    next_state = fifo_rd_val ? START : IDLE;
         START:   if (last_tick) next_state = DATA;
         DATA:    if (last_tick && (bit_cnt == LAST_DATA)) next_state = STOP;
         STOP: begin
            if (last_tick && (bit_cnt == LAST_STOP)) begin
               next_state = enable ? REQ : IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // bit_cnt indexes data bits in DATA and is reused to count stop bits in STOP
   always_comb begin
      shift_d   = shift_reg;
      bit_cnt_d = bit_cnt;
      case (state)
         WAIT: begin
            if (fifo_rd_val) begin
               shift_d   = fifo_rd_data;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (last_tick) begin
               shift_d   = shift_reg >> 1;
               bit_cnt_d = (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
            end
         end
         STOP: begin
            if (last_tick) begin
               bit_cnt_d = (bit_cnt == LAST_STOP) ? '0 : bit_cnt + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Outputs are decoded from the upcoming state so they can be registered
   // yet still line up with the state they belong to.
   always_comb begin
      tx_d    = TX_IDLE_LEVEL;
      rd_en_d = (next_state == REQ);
      busy_d  = (next_state != IDLE);
      done_d  = (state == STOP) && (tick_count == NEAR_END) && (bit_cnt == LAST_STOP);
      case (next_state)
         START:   tx_d = START_LEVEL;
         DATA:    tx_d = shift_d[0];
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg  <= '0;
         bit_cnt    <= '0;
         tx         <= TX_IDLE_LEVEL;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         shift_reg  <= shift_d;
         bit_cnt    <= bit_cnt_d;
         tx         <= tx_d;
         fifo_rd_en <= rd_en_d;
         busy       <= busy_d;
         frame_done <= done_d;
      end
   end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx with a small queue-based FIFO read model;
// frames are compared bit by bit against hand-built start/data/stop patterns.
module tb_fifo_serial_tx;

   localparam int DATA_WIDTH   = 8;
   localparam int CLKS_PER_BIT = 4;
   localparam int STOP_BITS    = 1;
   localparam int FRAME_CYCLES = (1 + DATA_WIDTH + STOP_BITS) * CLKS_PER_BIT;

   typedef struct {
      logic [7:0] word;
      logic [9:0] exp_frame;
      int         exp_wait;
      string      name;
   } frame_vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       fifo_rd_en;
   logic [7:0] fifo_rd_data = 8'h00;
   logic       fifo_rd_val  = 1'b0;
   logic       tx;
   logic       busy;
   logic       frame_done;

   logic [7:0] fifo_q[$];
   int         checks       = 0;
   int         errors       = 0;
   int         rd_en_pulses = 0;
   frame_vec_t vecs[4];

   always #5 clk = ~clk;

   fifo_serial_tx #(
      .DATA_WIDTH  (DATA_WIDTH),
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .STOP_BITS   (STOP_BITS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .fifo_rd_en  (fifo_rd_en),
      .fifo_rd_data(fifo_rd_data),
      .fifo_rd_val (fifo_rd_val),
      .tx          (tx),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   // FIFO read side: data and a sticky valid appear the cycle after a read request
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (fifo_q.size() > 0) begin
            fifo_rd_data <= fifo_q.pop_front();
            fifo_rd_val  <= 1'b1;
         end else begin
            fifo_rd_val <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (fifo_rd_en === 1'b1) rd_en_pulses++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en);
      reset  = rst;
      enable = en;
   endtask

   task automatic waitTxFall(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (tx === 1'b0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Leaves the caller on the negedge of the last stop-bit cycle
   task automatic runFrame(input string name, input logic [9:0] exp_frame, input int exp_wait,
                           output int waited);
      bit ok;
      waitTxFall(waited, ok);
      checkOutput({name, "_started"}, 32'(ok), 32'd1);
      if (!ok) return;
      if (exp_wait > 0) checkOutput({name, "_latency"}, waited, exp_wait);
      for (int i = 0; i < FRAME_CYCLES; i++) begin
         if (i > 0) @(negedge clk);
         checkOutput($sformatf("%s_tx[%0d]", name, i), 32'(tx), 32'(exp_frame[i / CLKS_PER_BIT]));
         checkOutput($sformatf("%s_done[%0d]", name, i), 32'(frame_done), 32'(i == FRAME_CYCLES - 1));
         checkOutput($sformatf("%s_busy[%0d]", name, i), 32'(busy), 32'd1);
      end
   endtask

   initial begin
      int  waited;
      int  p0;
      int  busy_hi;
      bit  ok;

      vecs[0] = '{8'hA5, 10'h34A, 3, "frame_a5"};
      vecs[1] = '{8'h01, 10'h202, 3, "frame_01"};
      vecs[2] = '{8'hFF, 10'h3FE, 3, "frame_ff"};
      vecs[3] = '{8'h80, 10'h300, 3, "frame_80"};

      // Reset and idle with enable low
      applyStimulus(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("reset_tx", 32'(tx), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
      checkOutput("reset_done", 32'(frame_done), 32'd0);
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput($sformatf("idle_tx[%0d]", i), 32'(tx), 32'd1);
      end
      checkOutput("idle_rd_en_pulses", rd_en_pulses, 0);
      checkOutput("idle_busy", 32'(busy), 32'd0);

      // Single frame followed by back-to-back frames from a preloaded FIFO
      foreach (vecs[k]) fifo_q.push_back(vecs[k].word);
      applyStimulus(1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         runFrame(vecs[k].name, vecs[k].exp_frame, vecs[k].exp_wait, waited);
      end
      checkOutput("table_rd_en_pulses", rd_en_pulses, 4);

      // Empty FIFO polling: REQ, WAIT, IDLE repeating
      p0      = rd_en_pulses;
      busy_hi = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checkOutput($sformatf("poll_tx[%0d]", i), 32'(tx), 32'd1);
         if (busy === 1'b1) busy_hi++;
      end
      checkOutput("poll_rd_en_pulses", rd_en_pulses - p0, 4);
      checkOutput("poll_busy_cycles", busy_hi, 8);
      fifo_q.push_back(8'h3C);
      runFrame("frame_3c", 10'h278, 0, waited);
      checkOutput("poll_fetch_latency", 32'(waited <= 5), 32'd1);

      // Enable dropped in the middle of the data bits
      applyStimulus(1'b0, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("drop_pre_busy", 32'(busy), 32'd0);
      p0 = rd_en_pulses;
      fifo_q.push_back(8'h5A);
      fifo_q.push_back(8'h77);
      applyStimulus(1'b0, 1'b1);
      fork
         runFrame("frame_5a", 10'h2B4, 3, waited);
         begin
            repeat (15) @(negedge clk);
            applyStimulus(1'b0, 1'b0);
         end
      join
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput($sformatf("drop_idle_tx[%0d]", i), 32'(tx), 32'd1);
      end
      checkOutput("drop_rd_en_pulses", rd_en_pulses - p0, 1);
      checkOutput("drop_busy", 32'(busy), 32'd0);

      // Reset in the middle of a frame, then a clean frame afterwards
      applyStimulus(1'b0, 1'b1);
      waitTxFall(waited, ok);
      checkOutput("frame_77_started", 32'(ok), 32'd1);
      repeat (17) @(negedge clk);
      checkOutput("pre_reset_tx", 32'(tx), 32'd0);
      applyStimulus(1'b1, 1'b1);
      #1;
      checkOutput("async_reset_tx", 32'(tx), 32'd1);
      checkOutput("async_reset_busy", 32'(busy), 32'd0);
      checkOutput("async_reset_done", 32'(frame_done), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("held_reset_tx", 32'(tx), 32'd1);
      fifo_q.push_back(8'hC3);
      applyStimulus(1'b0, 1'b1);
      runFrame("frame_c3", 10'h386, 3, waited);

      applyStimulus(1'b0, 1'b0);
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
